// File: rtl/heater_pkg.sv
// heater_pkg: shared types, default sizing and popcount for the heater sequencer.
package heater_pkg;
    typedef enum logic {IDLE, DWELL} seq_state_t;
    localparam int HEATER_N = 16;
    localparam int HEATER_MAX_ON = 8;
    localparam int HEATER_STEP_CYCLES = 3000;
    function automatic logic [6:0] popcount(input logic [63:0] v);
        popcount = '0;
        for (int i = 0; i < 64; i++) popcount += 7'(v[i]);
    endfunction
endpackage

// File: rtl/heater_lsb_pick.sv
// heater_lsb_pick: combinational one-hot select of the lowest set request bit.
module heater_lsb_pick #(
    parameter int N = 16
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);
    assign gnt = req & (~req + N'(1));
endmodule

// File: rtl/heater_sequencer.sv
// heater_sequencer: staggered soft-start of N heater channels capped at MAX_ON, with error capture.
// Define HEATER_SEQ_SHED_EN to drop and hold off channels whose sticky error is set.
module heater_sequencer
    import heater_pkg::*;
#(
    parameter int N = HEATER_N,
    parameter int MAX_ON = HEATER_MAX_ON,
    parameter int STEP_CYCLES = HEATER_STEP_CYCLES,
    parameter int CNT_W = 16,
    localparam int AW = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     enable_req,
    input  logic [N-1:0]     heater_error,
    input  logic [N-1:0]     err_clear,
    output logic [N-1:0]     heater_enable,
    output logic [N-1:0]     err_sticky,
    output logic [AW-1:0]    active_count,
    output logic             ramping,
    output logic [CNT_W-1:0] err_total
);
    localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] ERR_MAX = {CNT_W{1'b1}};
    seq_state_t state;
    logic [TW-1:0] cnt;
    logic [N-1:0] heater_error_d, blocked, pending, pick, grant, en_next, rise;
    logic [CNT_W+6:0] err_sum;
    logic room, slot;
`ifdef HEATER_SEQ_SHED_EN
    assign blocked = err_sticky;
`else
    assign blocked = '0;
`endif
    assign pending = enable_req & ~heater_enable & ~blocked;
    assign room = active_count < AW'(MAX_ON);
    assign slot = (state == IDLE) || (cnt == '0);
    heater_lsb_pick #(.N(N)) u_pick (.req(pending), .gnt(pick));
    // room uses the pre-drop count so a drop never lets two channels in at once
    assign grant = (slot && room) ? pick : '0;
    assign en_next = (heater_enable & enable_req & ~blocked) | grant;
    assign rise = heater_error & ~heater_error_d & heater_enable;
    assign err_sum = (CNT_W+7)'(err_total) + (CNT_W+7)'(popcount(64'(rise)));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            heater_enable <= '0;
            heater_error_d <= '0;
            err_sticky <= '0;
            active_count <= '0;
            ramping <= 1'b0;
            err_total <= '0;
        end else begin
            heater_enable <= en_next;
            active_count <= AW'(popcount(64'(en_next)));
            ramping <= |(enable_req & ~heater_enable);
            heater_error_d <= heater_error;
            err_sticky <= (err_sticky & ~err_clear) | (heater_error & heater_enable);
            err_total <= (err_sum > (CNT_W+7)'(ERR_MAX)) ? ERR_MAX : err_sum[CNT_W-1:0];
            if (|grant) begin
                cnt <= TW'(STEP_CYCLES - 1);
                state <= (STEP_CYCLES == 1) ? IDLE : DWELL;
            end else if (state == DWELL) begin
                if (cnt != '0) cnt <= cnt - TW'(1);
                else state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_heater_sequencer.sv
// tb_heater_sequencer: directed and randomized checks of heater_sequencer against a grant-spacing model.
module tb_heater_sequencer;
    localparam int N = 16;
    localparam int MAX_ON = 8;
    localparam int STEP = 10;
    localparam int CNT_W = 3;
    localparam int AW = $clog2(N + 1);
    localparam int TMAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] enable_req = '0, heater_error = '0, err_clear = '0;
    logic [N-1:0] heater_enable, err_sticky;
    logic [AW-1:0] active_count;
    logic ramping;
    logic [CNT_W-1:0] err_total;

    always #5 clk = ~clk;

    heater_sequencer #(.N(N), .MAX_ON(MAX_ON), .STEP_CYCLES(STEP), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .enable_req(enable_req), .heater_error(heater_error),
        .err_clear(err_clear), .heater_enable(heater_enable), .err_sticky(err_sticky),
        .active_count(active_count), .ramping(ramping), .err_total(err_total)
    );

    int tests = 0, fails = 0;
    logic [N-1:0] m_en, m_sticky, m_err_d;
    logic m_ramp;
    int m_total, since;

    function automatic int popc(input logic [N-1:0] v);
        popc = 0;
        for (int i = 0; i < N; i++) popc += int'(v[i]);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_en = '0; m_sticky = '0; m_err_d = '0; m_ramp = 1'b0; m_total = 0; since = STEP;
    endtask

    // Grants are allowed once STEP edges have passed since the previous grant.
    task automatic model_step();
        logic [N-1:0] blk, pend, grant, rise;
`ifdef HEATER_SEQ_SHED_EN
        blk = m_sticky;
`else
        blk = '0;
`endif
        pend = enable_req & ~m_en & ~blk;
        grant = '0;
        if (pend != '0 && popc(m_en) < MAX_ON && since >= STEP)
            for (int i = 0; i < N; i++) if (pend[i] && grant == '0) grant[i] = 1'b1;
        rise = heater_error & ~m_err_d & m_en;
        m_total = (m_total + popc(rise) > TMAX) ? TMAX : m_total + popc(rise);
        m_sticky = (m_sticky & ~err_clear) | (heater_error & m_en);
        m_ramp = |(enable_req & ~m_en);
        m_en = (m_en & enable_req & ~blk) | grant;
        m_err_d = heater_error;
        since = (grant != '0) ? 1 : (since < STEP ? since + 1 : since);
    endtask

    task automatic compare_all();
        check("enable", 64'(heater_enable), 64'(m_en));
        check("sticky", 64'(err_sticky), 64'(m_sticky));
        check("active_count", 64'(active_count), 64'(popc(m_en)));
        check("ramping", 64'(ramping), 64'(m_ramp));
        check("err_total", 64'(err_total), 64'(m_total));
    endtask

    task automatic step(input logic [N-1:0] req, input logic [N-1:0] err, input logic [N-1:0] clr);
        enable_req = req; heater_error = err; err_clear = clr;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("rst_enable", 64'(heater_enable), 64'd0);
        check("rst_count", 64'(active_count), 64'd0);
        check("rst_total", 64'(err_total), 64'd0);
        check("rst_sticky", 64'(err_sticky), 64'd0);
        check("rst_ramping", 64'(ramping), 64'd0);
        @(negedge clk) rst = 1'b0;
    endtask

    initial begin
        logic [N-1:0] req;
        model_reset();
        repeat (3) @(posedge clk);
        #1 compare_all();
        @(negedge clk) rst = 1'b0;
        for (int e = 1; e <= 80; e++) begin
            step('1, '0, '0);
            if (e == 1) check("grant_e1", 64'(heater_enable), 64'h0001);
            if (e == 10) check("dwell_e10", 64'(heater_enable), 64'h0001);
            if (e == 11) check("grant_e11", 64'(heater_enable), 64'h0003);
            if (e == 70) check("grant_e70", 64'(heater_enable), 64'h007F);
            if (e == 71) check("grant_e71", 64'(heater_enable), 64'h00FF);
            if (e == 80) check("cap_count", 64'(active_count), 64'd8);
            if (e == 80) check("cap_ramping", 64'(ramping), 64'd1);
        end
        req = 16'hFFF7;
        step(req, '0, '0);
        check("drop_enable", 64'(heater_enable), 64'h00F7);
        check("drop_count", 64'(active_count), 64'd7);
        step(req, '0, '0);
        check("regrant_ch8", 64'(heater_enable), 64'h01F7);
        check("regrant_ramping", 64'(ramping), 64'd1);
        step(req, 16'h0020, '0);
        step(req, 16'h0020, 16'h0020);
`ifndef HEATER_SEQ_SHED_EN
        check("set_wins", 64'(err_sticky[5]), 64'd1);
`endif
        step(req, 16'h0020, '0);
        step(req, '0, '0);
        check("err_once", 64'(err_total), 64'd1);
        step(req, '0, 16'h0020);
        check("clear_sticky", 64'(err_sticky[5]), 64'd0);
        for (int p = 0; p < 2; p++) begin
            step(req, 16'h0007, '0);
            step(req, '0, '0);
        end
        check("saturate", 64'(err_total), 64'd7);
        step(req, '0, '1);
        step(req, 16'h0008, '0);
        step(req, '0, '0);
        check("disabled_sticky", 64'(err_sticky[3]), 64'd0);
        check("disabled_total", 64'(err_total), 64'd7);
        async_reset();
        for (int e = 0; e < 35; e++) step(16'h000F, '0, '0);
        check("four_on", 64'(active_count), 64'd4);
        async_reset();
        step(16'h000F, '0, '0);
        check("post_rst_grant", 64'(heater_enable), 64'h0001);
        for (int b = 0; b < 4; b++) begin
            async_reset();
            req = N'($urandom);
            for (int c = 0; c < 600; c++) begin
                if ($urandom_range(0, 7) == 0) req[$urandom_range(0, N - 1)] ^= 1'b1;
                step(req, N'($urandom & $urandom & $urandom & $urandom),
                     N'($urandom & $urandom & $urandom & $urandom));
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
